// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared constants and types for the serial register-write tracer
package debug_pkg;

   // Frame is start + 37 payload bits + parity + stop.
   localparam int FRAME_BITS   = 40;
   localparam int PAYLOAD_BITS = 37;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   // One captured register-file write.
   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_record_t;

   // Payload in shift order: bit 0 goes on the line first (addr LSB).
   function automatic logic [PAYLOAD_BITS-1:0] record_payload(input wr_record_t r);
      return {r.data, r.addr};
   endfunction

endpackage

// File: rtl/debug_fifo.sv
// rtl/debug_fifo.sv - synchronous record FIFO between writeback capture and the serialiser
module debug_fifo
   import debug_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  wr_record_t push_data,
   input  logic       pop,
   output wr_record_t pop_data,
   output logic       full,
   output logic       empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   wr_record_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty    = (count == '0);
   assign full     = (count == DEPTH_CNT);
   assign pop_data = mem[rd_ptr];

   // A pop frees a slot on the same edge, so a full FIFO can still take a push then.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage array; contents are only meaningful between rd_ptr and wr_ptr.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Occupancy count drives full/empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/debug_tx.sv
// rtl/debug_tx.sv - serialises register-file writes onto a one-wire debug line
module debug_tx
   import debug_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic        clr_overflow,
   output logic        debug_output,
   output logic        busy,
   output logic        overflow
);

   localparam logic [7:0] LAST_CLK = 8'(CLKS_PER_BIT - 1);
   localparam logic [5:0] LAST_BIT = 6'(PAYLOAD_BITS - 1);

   tx_state_t                state;
   tx_state_t                state_nxt;
   logic [7:0]               clk_cnt;
   logic [5:0]               bit_cnt;
   logic [PAYLOAD_BITS-1:0]  shreg;
   logic                     par_bit;
   logic                     line;

   wr_record_t               wr_rec;
   wr_record_t               head_rec;
   logic [PAYLOAD_BITS-1:0]  head_payload;
   logic                     wr_valid;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     load_frame;
   logic                     bit_end;
   logic                     last_data_bit;
   logic                     drop;

   // Writes to r0 are architecturally meaningless and never traced.
   assign wr_valid     = wr_en && (wr_addr != 5'd0);
   assign wr_rec.addr  = wr_addr;
   assign wr_rec.data  = wr_data;
   assign head_payload = record_payload(head_rec);

   assign bit_end       = (clk_cnt == LAST_CLK);
   assign last_data_bit = (bit_cnt == LAST_BIT);

   // A new frame starts straight from idle, or back-to-back at the end of a stop bit.
   assign load_frame = !fifo_empty &&
                       ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

   // Dropped only when full and nothing leaves on this edge.
   assign drop = wr_valid && fifo_full && !load_frame;

   assign debug_output = line;
   assign busy         = (state != ST_IDLE) || !fifo_empty;

   debug_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_valid),
      .push_data (wr_rec),
      .pop       (load_frame),
      .pop_data  (head_rec),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Frame sequencing: each state lasts one bit period, DATA lasts 37.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) state_nxt = ST_START;
         end
         ST_START: begin
            if (bit_end) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end && last_data_bit) state_nxt = ST_PARITY;
         end
         ST_PARITY: begin
            if (bit_end) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (bit_end) state_nxt = fifo_empty ? ST_IDLE : ST_START;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Bit-period divider; restarts with every frame so the start bit is full length.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_cnt <= '0;
      end else if (load_frame || (state == ST_IDLE) || bit_end) begin
         clk_cnt <= '0;
      end else begin
         clk_cnt <= clk_cnt + 8'd1;
      end
   end

   // Payload bit index, 0..36 while in DATA.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt <= '0;
      end else if (load_frame) begin
         bit_cnt <= '0;
      end else if ((state == ST_DATA) && bit_end && !last_data_bit) begin
         bit_cnt <= bit_cnt + 6'd1;
      end
   end

   // Payload shifter and parity latch; shreg[0] is always the next payload bit to send.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg   <= '0;
         par_bit <= 1'b0;
      end else if (load_frame) begin
         shreg   <= head_payload;
         par_bit <= ^head_payload;
      end else if (bit_end && ((state == ST_START) || (state == ST_DATA))) begin
         shreg   <= shreg >> 1;
      end
   end

   // Registered line driver: low from the edge a frame is loaded, high when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         line <= 1'b1;
      end else if (load_frame) begin
         line <= 1'b0;
      end else if (bit_end) begin
         case (state)
            ST_START:  line <= shreg[0];
            ST_DATA:   line <= last_data_bit ? par_bit : shreg[0];
            ST_PARITY: line <= 1'b1;
            default:   line <= 1'b1;
         endcase
      end
   end

   // Sticky overflow; a drop on the same edge as a clear keeps it set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_debug_tx.sv
// tb/tb_debug_tx.sv - self-checking bench for debug_tx with a line-level receiver model
module tb_debug_tx;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } trec;

   logic        clk = 1'b0;
   logic        rst, wr_en, clr_overflow;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        debug_output, busy, overflow;

   logic        rst1, wr_en1, clr1;
   logic [4:0]  wr_addr1;
   logic [31:0] wr_data1;
   logic        debug_output1, busy1, overflow1;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   rec_on = 1'b0;
   logic line_q[$];
   logic busy_q[$];
   logic line1_q[$];
   trec  exp_q[$];

   always #5 clk = ~clk;

   debug_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .clr_overflow(clr_overflow), .debug_output(debug_output), .busy(busy), .overflow(overflow)
   );

   debug_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut1 (
      .clk(clk), .rst(rst1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
      .clr_overflow(clr1), .debug_output(debug_output1), .busy(busy1), .overflow(overflow1)
   );

   // Trace index k holds the line value after the k-th edge since start_rec.
   always @(negedge clk) begin
      if (rec_on) begin
         line_q.push_back(debug_output);
         busy_q.push_back(busy);
         line1_q.push_back(debug_output1);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h required %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic start_rec();
      line_q.delete();
      busy_q.delete();
      line1_q.delete();
      rec_on = 1'b1;
      cyc = 0;
   endtask

   task automatic drive4(input logic en, input logic [4:0] a, input logic [31:0] d, input logic clr);
      wr_en = en; wr_addr = a; wr_data = d; clr_overflow = clr;
      step();
      wr_en = 1'b0; clr_overflow = 1'b0;
   endtask

   task automatic drive1(input logic [4:0] a, input logic [31:0] d);
      wr_en1 = 1'b1; wr_addr1 = a; wr_data1 = d;
      step();
      wr_en1 = 1'b0;
   endtask

   task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
      trec r;
      r.a = a; r.d = d;
      exp_q.push_back(r);
   endtask

   function automatic logic samp(input int which, input int i);
      if (which == 0) return (i < line_q.size()) ? line_q[i] : 1'bx;
      return (i < line1_q.size()) ? line1_q[i] : 1'bx;
   endfunction

   // Expected 40-bit frame, index 0 is sent first.
   function automatic logic [39:0] frame_of(input logic [4:0] a, input logic [31:0] d);
      logic [39:0] f;
      f = '0;
      for (int i = 0; i < 5; i++)  f[1+i] = a[i];
      for (int i = 0; i < 32; i++) f[6+i] = d[i];
      f[38] = 1'((($countones(a) + $countones(d)) % 2));
      f[39] = 1'b1;
      return f;
   endfunction

   // Cycle-exact comparison of the traced line against back-to-back frames of exp_q.
   task automatic check_frames(input int which, input int base, input int cpb, input string tag);
      int mism;
      int pos;
      logic [39:0] f;
      chk($sformatf("%s_pre_idle", tag), samp(which, base - 1), 1'b1);
      pos = base;
      for (int k = 0; k < exp_q.size(); k++) begin
         f = frame_of(exp_q[k].a, exp_q[k].d);
         mism = 0;
         for (int b = 0; b < 40; b++)
            for (int c = 0; c < cpb; c++)
               if (samp(which, pos + b*cpb + c) !== f[b]) mism++;
         chk($sformatf("%s_wave%0d_bad_samples", tag, k), mism, 0);
         pos += 40 * cpb;
      end
      mism = 0;
      for (int i = pos; i < pos + 8; i++)
         if (samp(which, i) !== 1'b1) mism++;
      chk($sformatf("%s_post_idle_bad_samples", tag), mism, 0);
   endtask

   // Receiver: find start bits, sample mid-bit, rebuild records, compare with exp_q.
   task automatic decode_cmp(input int which, input int cpb, input string tag);
      trec got[$];
      trec r;
      logic [39:0] v;
      int i;
      int n;
      n = line_q.size();
      i = 0;
      while (i < n) begin
         if (samp(which, i) === 1'b0) begin
            for (int b = 0; b < 40; b++) v[b] = samp(which, i + b*cpb + cpb/2);
            chk($sformatf("%s_rx%0d_parity", tag, got.size()), v[38], ^v[37:1]);
            chk($sformatf("%s_rx%0d_stop", tag, got.size()), v[39], 1'b1);
            r.a = v[5:1];
            r.d = v[37:6];
            got.push_back(r);
            i += 40 * cpb;
         end else begin
            i++;
         end
      end
      chk($sformatf("%s_rx_count", tag), got.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got.size(); k++)
         chk($sformatf("%s_rx%0d_record", tag, k), {got[k].a, got[k].d}, {exp_q[k].a, exp_q[k].d});
   endtask

   initial begin
      logic [39:0] v;
      int bad;
      int n;
      int acc;
      int first;
      int c;
      logic [4:0] a;
      logic [31:0] d;

      rst = 1'b1; rst1 = 1'b1;
      wr_en = 0; wr_addr = 0; wr_data = 0; clr_overflow = 0;
      wr_en1 = 0; wr_addr1 = 0; wr_data1 = 0; clr1 = 0;
      #1;
      rst = 1'b0; rst1 = 1'b0;
      #1;
      chk("reset_line", debug_output, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_overflow", overflow, 1'b0);
      chk("reset_line_cpb1", debug_output1, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1; rst1 = 1'b1;

      // Single write addr 8, data 1.
      start_rec();
      exp_q.delete();
      push_exp(5'd8, 32'h1);
      drive4(1'b1, 5'd8, 32'h0000_0001, 1'b0);
      run_to(175);
      check_frames(0, 2, 4, "single");
      decode_cmp(0, 4, "single");
      for (int b = 0; b < 40; b++) v[b] = samp(0, 2 + b*4 + 2);
      chk("single_bit_pattern", v, 40'h80_0000_0050);
      chk("single_busy_before", busy_q[0], 1'b0);
      chk("single_busy_accept", busy_q[1], 1'b1);
      chk("single_busy_stop", busy_q[161], 1'b1);
      chk("single_busy_after", busy_q[162], 1'b0);

      // r0 write is ignored entirely.
      start_rec();
      drive4(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
      run_to(30);
      bad = 0;
      for (int i = 0; i < line_q.size(); i++)
         if (line_q[i] !== 1'b1 || busy_q[i] !== 1'b0) bad++;
      chk("r0_ignored_bad_samples", bad, 0);
      chk("r0_no_overflow", overflow, 1'b0);

      // Random bursts with interleaved r0 writes, never exceeding capacity.
      for (int it = 0; it < 3; it++) begin
         start_rec();
         exp_q.delete();
         n = $urandom_range(1, 4);
         acc = 0;
         first = -1;
         c = 0;
         while (acc < n) begin
            d = $urandom;
            if ($urandom_range(0, 3) == 0) begin
               drive4(1'b1, 5'd0, d, 1'b0);
            end else begin
               a = 5'($urandom_range(1, 31));
               push_exp(a, d);
               if (first < 0) first = c;
               acc++;
               drive4(1'b1, a, d, 1'b0);
            end
            c++;
         end
         run_to(first + 2 + n*160 + 20);
         check_frames(0, first + 2, 4, $sformatf("rand%0d", it));
         decode_cmp(0, 4, $sformatf("rand%0d", it));
         chk($sformatf("rand%0d_no_overflow", it), overflow, 1'b0);
      end

      // Six writes into a depth-4 FIFO: five frames, sixth dropped.
      start_rec();
      exp_q.delete();
      for (int k = 1; k <= 6; k++) begin
         if (k <= 5) push_exp(5'(k), 32'hA5A5_0000 + 32'(k));
         drive4(1'b1, 5'(k), 32'hA5A5_0000 + 32'(k), 1'b0);
      end
      chk("six_overflow_set", overflow, 1'b1);
      run_to(2 + 5*160 + 20);
      check_frames(0, 2, 4, "six");
      decode_cmp(0, 4, "six");
      chk("six_overflow_sticky", overflow, 1'b1);

      // Clear alone, then drop with clear on the same edge, then push+pop while full.
      drive4(1'b0, 5'd0, 32'h0, 1'b1);
      chk("clr_alone", overflow, 1'b0);
      start_rec();
      exp_q.delete();
      for (int k = 1; k <= 6; k++) begin
         if (k <= 5) push_exp(5'(k), 32'h3C3C_0000 + 32'(k));
         drive4(1'b1, 5'(k), 32'h3C3C_0000 + 32'(k), (k == 6));
      end
      chk("drop_beats_clear", overflow, 1'b1);
      drive4(1'b0, 5'd0, 32'h0, 1'b1);
      chk("clr_after_drop", overflow, 1'b0);
      run_to(161);
      push_exp(5'd7, 32'hDEAD_BEEF);
      drive4(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
      chk("full_push_pop_no_overflow", overflow, 1'b0);
      run_to(2 + 6*160 + 20);
      check_frames(0, 2, 4, "fullpp");
      decode_cmp(0, 4, "fullpp");

      // Reset 70 cycles into a frame with two records queued.
      start_rec();
      for (int k = 1; k <= 3; k++) drive4(1'b1, 5'(k + 10), $urandom, 1'b0);
      run_to(72);
      rst = 1'b0;
      #1;
      chk("midreset_line", debug_output, 1'b1);
      chk("midreset_busy", busy, 1'b0);
      step();
      step();
      chk("midreset_line_held", debug_output, 1'b1);
      rst = 1'b1;
      start_rec();
      run_to(400);
      bad = 0;
      for (int i = 0; i < line_q.size(); i++)
         if (line_q[i] !== 1'b1 || busy_q[i] !== 1'b0) bad++;
      chk("after_reset_silent_bad_samples", bad, 0);
      chk("after_reset_overflow", overflow, 1'b0);

      // One clock per bit.
      start_rec();
      exp_q.delete();
      push_exp(5'd31, 32'h8000_0000);
      drive1(5'd31, 32'h8000_0000);
      run_to(60);
      check_frames(1, 2, 1, "cpb1");
      decode_cmp(1, 1, "cpb1");
      chk("cpb1_parity_bit", samp(1, 2 + 38), 1'b0);

      start_rec();
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
         a = 5'($urandom_range(1, 31));
         d = $urandom;
         push_exp(a, d);
         drive1(a, d);
      end
      run_to(2 + 3*40 + 20);
      check_frames(1, 2, 1, "cpb1_rand");
      decode_cmp(1, 1, "cpb1_rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
